// File: rtl/mac_result_packer.sv
// mac_result_packer: requantizes reduced MAC accumulator vectors (round half up,
// arithmetic shift, saturate) into a packed word, buffers it in a show-ahead
// FIFO and streams it out with TLAST framing.
// Optional feature: define MAC_PACKER_SAT_CNT_EN to build the saturated-lane
// counter; otherwise sat_cnt is tied to zero.
module mac_result_packer #(
  parameter int TILE_SIZE      = 4,
  parameter int ACC_WIDTH      = 32,
  parameter int DATA_WIDTH     = 16,
  parameter int FRAC_BITS      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int VECS_PER_FRAME = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_axis_TVALID,
  output logic                            s_axis_TREADY,
  input  logic [TILE_SIZE*ACC_WIDTH-1:0]  s_vec,
  output logic                            m_axis_TVALID,
  input  logic                            m_axis_TREADY,
  output logic [TILE_SIZE*DATA_WIDTH-1:0] m_axis_TDATA,
  output logic                            m_axis_TLAST,
  output logic [15:0]                     sat_cnt
);

  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WW     = (VECS_PER_FRAME > 1) ? $clog2(VECS_PER_FRAME) : 1;
  localparam int WORD_W = TILE_SIZE * DATA_WIDTH;

  // Requantization constants in the widened (ACC_WIDTH+1) lane domain.
  localparam logic        [ACC_WIDTH:0] RND  = {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_BITS - 1);
  localparam logic signed [ACC_WIDTH:0] MAXV = {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MINV = {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic                           stg_valid_q;
  logic [TILE_SIZE*ACC_WIDTH-1:0] stg_vec_q;
  logic [WORD_W-1:0]              mem_q [FIFO_DEPTH];
  logic [AW-1:0]                  wr_ptr_q, rd_ptr_q;
  logic [AW:0]                    fifo_cnt_q, fifo_cnt_d, occ;
  logic [WW-1:0]                  word_idx_q, word_idx_d;
  logic [WORD_W-1:0]              pack_word;
  logic [TILE_SIZE-1:0]           lane_sat;
  logic                           s_hs, push, pop;

  // Ready depends only on registered occupancy, counting the staged vector
  // that is guaranteed to land in the FIFO next edge.
  assign occ           = fifo_cnt_q + (AW+1)'(stg_valid_q);
  assign s_axis_TREADY = occ < (AW+1)'(FIFO_DEPTH);
  assign s_hs          = s_axis_TVALID && s_axis_TREADY;
  assign push          = stg_valid_q;
  assign m_axis_TVALID = (fifo_cnt_q != '0);
  assign pop           = m_axis_TVALID && m_axis_TREADY;
  assign m_axis_TDATA  = m_axis_TVALID ? mem_q[rd_ptr_q] : '0;
  assign m_axis_TLAST  = m_axis_TVALID && (word_idx_q == WW'(VECS_PER_FRAME - 1));

  // Stage 1: capture the accepted vector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_valid_q <= 1'b0;
    end else begin
      stg_valid_q <= s_hs;
      if (s_hs) stg_vec_q <= s_vec;
    end
  end

  // Stage 2: per-lane round, shift and clamp of the staged vector.
  for (genvar i = 0; i < TILE_SIZE; i++) begin : g_lane
    logic        [ACC_WIDTH-1:0]  lane;
    logic signed [ACC_WIDTH:0]    ext, rnd, shf;
    logic        [DATA_WIDTH-1:0] q;
    logic                         sat;
    assign lane = stg_vec_q[i*ACC_WIDTH +: ACC_WIDTH];
    assign ext  = {lane[ACC_WIDTH-1], lane};
    assign rnd  = ext + RND;
    assign shf  = rnd >>> FRAC_BITS;
    // Clamp to the signed output range and flag the lane when it clips.
    always_comb begin
      q   = shf[DATA_WIDTH-1:0];
      sat = 1'b0;
      if (shf > MAXV) begin
        q   = MAXV[DATA_WIDTH-1:0];
        sat = 1'b1;
      end else if (shf < MINV) begin
        q   = MINV[DATA_WIDTH-1:0];
        sat = 1'b1;
      end
    end
    assign pack_word[i*DATA_WIDTH +: DATA_WIDTH] = q;
    assign lane_sat[i] = sat;
  end

  // FIFO storage; written whenever a staged word is present.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pack_word;
  end

  // Occupancy and frame position next-state.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    word_idx_d = word_idx_q;
    if (push && !pop) fifo_cnt_d = fifo_cnt_q + 1'b1;
    if (!push && pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
    if (pop) word_idx_d = (word_idx_q == WW'(VECS_PER_FRAME - 1)) ? '0 : word_idx_q + 1'b1;
  end

  // FIFO pointers, occupancy and frame counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      word_idx_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      fifo_cnt_q <= fifo_cnt_d;
      word_idx_q <= word_idx_d;
    end
  end

`ifdef MAC_PACKER_SAT_CNT_EN
  localparam int PW = $clog2(TILE_SIZE + 1);
  logic [15:0]   sat_cnt_q, sat_cnt_d;
  logic [PW-1:0] sat_inc;
  logic [16:0]   sat_sum;

  // Add the number of clipped lanes per pushed word, sticking at all-ones.
  always_comb begin
    sat_inc = '0;
    for (int i = 0; i < TILE_SIZE; i++) sat_inc = sat_inc + PW'(lane_sat[i]);
    sat_sum   = {1'b0, sat_cnt_q} + 17'(sat_inc);
    sat_cnt_d = sat_cnt_q;
    if (push) sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  // Saturation counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`else
  logic unused_sat;
  assign unused_sat = ^lane_sat;
  assign sat_cnt    = 16'h0;
`endif

endmodule

// File: doc/mac_result_packer.md
# mac_result_packer

Downstream stage of the MAC memory controller. It accepts each reduced accumulator vector (TILE_SIZE × ACC_WIDTH) over an AXI-Stream style handshake, then rounds, shifts and saturates it back to DATA_WIDTH fixed point. The result is packed into one TILE_SIZE×DATA_WIDTH word, buffered in a small FIFO, and streamed out with TLAST marking frame boundaries. Back-pressure from the consumer reaches the MAC controller through `s_axis_TREADY`.

## Interface
- `TILE_SIZE`, default 4: lanes per vector.
- `ACC_WIDTH`, default 32: signed accumulator lane width.
- `DATA_WIDTH`, default 16: signed output lane width.
- `FRAC_BITS`, default 8: right shift applied at requantization. Must be ≥1.
- `FIFO_DEPTH`, default 4: output FIFO entries. Power of 2, ≥2.
- `VECS_PER_FRAME`, default 16: output words per TLAST frame. Must be ≥1.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `s_axis_TVALID`  in  1: input vector valid (driven by MAC controller `m_axis_TVALID`).
- `s_axis_TREADY`  out  1: block can accept an input vector this cycle.
- `s_vec`  in  [TILE_SIZE][ACC_WIDTH] signed: reduced accumulator vector.
- `m_axis_TVALID`  out  1: output word valid.
- `m_axis_TREADY`  in  1: consumer ready.
- `m_axis_TDATA`  out  TILE_SIZE*DATA_WIDTH: packed word; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `m_axis_TLAST`  out  1: last word of a frame.
- `sat_cnt`  out  16: saturated-lane event counter.

## Operation
- Input handshake: a vector is accepted when `s_axis_TVALID && s_axis_TREADY`.
- `s_axis_TREADY = (fifo_count + stg_valid) < FIFO_DEPTH`. It is combinational from registered state only, with no dependence on `s_axis_TVALID`.
- Stage 1 (capture): on acceptance, `s_vec` is registered and `stg_valid` is set. Otherwise `stg_valid` clears.
- Stage 2 (requantize and push): when `stg_valid` is set, each lane is processed and the packed word is written into the FIFO in the same cycle.
  - Sign-extend the lane to ACC_WIDTH+1 bits.
  - Add 2^(FRAC_BITS-1) (round half up).
  - Arithmetic shift right by FRAC_BITS.
  - Clamp to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- Saturation counting: each lane that clamps increments `sat_cnt` by 1. With several lanes clamping in one cycle, `sat_cnt` increases by the number of clamped lanes. `sat_cnt` saturates at 0xFFFF and does not wrap.
- FIFO: show-ahead. `m_axis_TDATA` is the head entry and `m_axis_TVALID = (fifo_count != 0)`.
  - Pop on `m_axis_TVALID && m_axis_TREADY`.
  - Push and pop in the same cycle leave `fifo_count` unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - The FIFO can never overflow, by construction of TREADY. A push with the FIFO full is a design error; the bench asserts it never happens.
- Frame counter `word_idx` (0..VECS_PER_FRAME−1):
  - It increments on each output handshake and wraps to 0 after VECS_PER_FRAME−1.
  - `m_axis_TLAST = m_axis_TVALID && (word_idx == VECS_PER_FRAME−1)`.
  - With VECS_PER_FRAME=1, TLAST accompanies every word.
- Output stability: once `m_axis_TVALID` is asserted, TDATA and TLAST are held until the handshake completes.

## Timing
- Reset (rst_n low at a rising edge): the FIFO empties, `stg_valid`=0, `word_idx`=0 and `sat_cnt`=0.
  - From the next cycle: `m_axis_TVALID`=0, `m_axis_TLAST`=0, `m_axis_TDATA`=0 and `s_axis_TREADY`=1.
  - Reset mid-stream discards all in-flight and buffered vectors without emitting them.
- Latency: a vector accepted at edge N is pushed at edge N+1. `m_axis_TVALID` is high during the cycle after edge N+1, so the minimum latency is 2 cycles.
- Throughput: 1 vector/cycle in steady state while `m_axis_TREADY`=1.
- Full-FIFO boundary:
  - With `m_axis_TREADY`=0, at most FIFO_DEPTH vectors are accepted and then `s_axis_TREADY` drops.
  - It reasserts the cycle after the first pop.
- Empty-FIFO boundary: the cycle after the last pop, `m_axis_TVALID`=0 unless a push occurred on the same edge.

## Configuration
- `MAC_PACKER_SAT_CNT_EN` defined: the saturation counter is built as described.
- `MAC_PACKER_SAT_CNT_EN` not defined: no counter logic is built and `sat_cnt` is tied to 16'h0. Clamping behaviour is identical in both cases.

## Test plan
All scenarios use default parameters.
- Rounding:
  - A lane of 0x00000180 (384) gives output lane 0x0002.
  - A lane of 0xFFFFFE80 (−384) gives 0xFFFF (−1).
  - A lane of 0x0000007F gives 0x0000.
  - `sat_cnt` stays 0.
- Saturation:
  - Lanes {0x7FFFFFFF, 0x80000000, 0x00800000, 0x007FFF00} give {0x7FFF, 0x8000, 0x7FFF, 0x7FFF}.
  - `sat_cnt`=3, because the last lane requantizes to exactly 32767 and is not clamped.
  - The output appears 2 cycles after acceptance.
- Back-pressure:
  - Hold `m_axis_TREADY`=0 and drive TVALID continuously.
  - Exactly 4 vectors are accepted, then `s_axis_TREADY`=0.
  - Release TREADY: 4 words drain in order, and TREADY reasserts one cycle after the first pop.
- Framing: stream 33 vectors with TREADY=1. TLAST is high on words 15 and 31 only, and word 32 has TLAST=0.
- Reset mid-stream: after 3 vectors are buffered, pulse rst_n low for 1 cycle. The next cycle shows TVALID=0, TREADY=1 and `sat_cnt`=0, and no stale word is ever emitted.
- Random stall: feed 200 random vectors with random TVALID/TREADY. Output equals the reference requantization in order, and no FIFO-overflow assertion fires.
